// File: rtl/reg_wb_arbiter.sv
// Register-file writeback arbiter: A has priority, B is forced through after STARVE_LIMIT denied cycles.
// Latency: grant is combinational, the write appears on we/waddr/wdata one cycle after acceptance.
// Backpressure: the loser sees ready=0 and holds its request; REG_WB_SCOREBOARD_EN adds the busy scoreboard.
module reg_wb_arbiter #(
    parameter int XLEN         = 64,
    parameter int STARVE_LIMIT = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_valid,
    input  logic [4:0]      a_addr,
    input  logic [XLEN-1:0] a_data,
    output logic            a_ready,
    input  logic            b_valid,
    input  logic [4:0]      b_addr,
    input  logic [XLEN-1:0] b_data,
    output logic            b_ready,
    output logic            we,
    output logic [4:0]      waddr,
    output logic [XLEN-1:0] wdata,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    output logic [31:0]     busy
);
    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic {PRIO_A, FORCE_B} state_t;

    state_t          state;
    logic [CW-1:0]   starve_cnt;
    logic [CW-1:0]   starve_nxt;
    logic            a_xfer;
    logic            b_xfer;
    logic            xfer;
    logic [4:0]      xfer_addr;
    logic [XLEN-1:0] xfer_data;

    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!rst) begin
            if (state == FORCE_B) begin
                b_ready = b_valid;
                a_ready = a_valid & ~b_valid;
            end else begin
                a_ready = a_valid;
                b_ready = b_valid & ~a_valid;
            end
        end
    end

    assign a_xfer    = a_valid & a_ready;
    assign b_xfer    = b_valid & b_ready;
    assign xfer      = a_xfer | b_xfer;
    assign xfer_addr = b_xfer ? b_addr : a_addr;
    assign xfer_data = b_xfer ? b_data : a_data;

    always_comb begin
        starve_nxt = '0;
        if (b_valid && !b_xfer)
            starve_nxt = (starve_cnt >= LIMIT) ? LIMIT : starve_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= PRIO_A;
            starve_cnt <= '0;
            we         <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
        end else begin
            starve_cnt <= starve_nxt;
            if (b_xfer)
                state <= PRIO_A;
            else if (starve_nxt >= LIMIT)
                state <= FORCE_B;
            // Writes to x0 are consumed but never reach the register file.
            we <= xfer && (xfer_addr != 5'd0);
            if (xfer && (xfer_addr != 5'd0)) begin
                waddr <= xfer_addr;
                wdata <= xfer_data;
            end
        end
    end

`ifdef REG_WB_SCOREBOARD_EN
    logic [31:1] busy_q;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;

    assign set_mask = issue_valid ? (32'd1 << issue_rd) : 32'd0;
    assign clr_mask = xfer ? (32'd1 << xfer_addr) : 32'd0;

    // A same-cycle issue to the register being written back keeps it busy.
    always_ff @(posedge clk) begin
        if (rst)
            busy_q <= '0;
        else
            busy_q <= (busy_q & ~clr_mask[31:1]) | set_mask[31:1];
    end

    assign busy = {busy_q, 1'b0};
`else
    logic unused_issue;
    assign unused_issue = ^{issue_valid, issue_rd};
    assign busy         = 32'h0;
`endif
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: directed scenarios then randomized traffic vs. a behavioural model.
module tb_reg_wb_arbiter;
    localparam int XLEN = 64;
    localparam int LIM  = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            a_valid, b_valid, a_ready, b_ready;
    logic [4:0]      a_addr, b_addr, waddr, issue_rd;
    logic [XLEN-1:0] a_data, b_data, wdata;
    logic            we, issue_valid;
    logic [31:0]     busy;

    always #5 clk = ~clk;

    reg_wb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .we(we), .waddr(waddr), .wdata(wdata),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .busy(busy)
    );

    int checks = 0;
    int passed = 0;

    // Model: B wins if A is idle or B has already been refused LIM cycles in a row.
    int              m_streak;
    logic            m_we;
    logic [4:0]      m_waddr;
    logic [XLEN-1:0] m_wdata;
    logic [31:0]     m_busy;
    logic            ga, gb, obs_a, obs_b;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        logic [4:0]      ad;
        logic [XLEN-1:0] dt;
        #3;
        gb = !rst && b_valid && (!a_valid || m_streak >= LIM);
        ga = !rst && a_valid && !gb;
        obs_a = a_ready;
        obs_b = b_ready;
        chk("a_ready", a_ready, ga);
        chk("b_ready", b_ready, gb);
        if (rst) begin
            m_streak = 0; m_we = 0; m_waddr = 0; m_wdata = 0; m_busy = 0;
        end else begin
            ad = gb ? b_addr : a_addr;
            dt = gb ? b_data : a_data;
            m_streak = (b_valid && !gb) ? ((m_streak >= LIM) ? LIM : m_streak + 1) : 0;
            m_we = (ga || gb) && ad != 0;
            if (m_we) begin
                m_waddr = ad;
                m_wdata = dt;
            end
`ifdef REG_WB_SCOREBOARD_EN
            if ((ga || gb) && ad != 0) m_busy[ad] = 1'b0;
            if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
`endif
        end
        @(posedge clk);
        #1;
        chk("we", we, m_we);
        chk("waddr", waddr, m_waddr);
        chk("wdata", wdata, m_wdata);
        chk("busy", busy, m_busy);
    endtask

    initial begin
        rst = 1; a_valid = 0; b_valid = 0; a_addr = 0; b_addr = 0;
        a_data = 0; b_data = 0; issue_valid = 0; issue_rd = 0;
        m_streak = 0; m_we = 0; m_waddr = 0; m_wdata = 0; m_busy = 0;
        step();
        step();
        rst = 0;

        // Lone A request is granted immediately and written next cycle.
        a_valid = 1; a_addr = 5; a_data = 64'h11;
        step();
        chk("r033_a_ready", obs_a, 1);
        chk("r033_we", we, 1);
        chk("r033_waddr", waddr, 5);
        chk("r033_wdata", wdata, 64'h11);
        a_valid = 0;

        // Both held: A, A, A, B, A.
        a_valid = 1; a_addr = 1; a_data = 64'hA1;
        b_valid = 1; b_addr = 2; b_data = 64'hB2;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("r034_grant", {obs_a, obs_b}, (i == 3) ? 2'b01 : 2'b10);
            if (obs_b) b_valid = 0;
        end
        a_valid = 0;

        // Write to x0 is accepted but suppressed.
        b_valid = 1; b_addr = 0; b_data = 64'hFF;
        step();
        chk("r035_b_ready", obs_b, 1);
        chk("r035_we", we, 0);
        b_valid = 0;

        // Scoreboard: set wins over same-cycle clear, later clear alone.
        issue_valid = 1; issue_rd = 9;
        step();
        b_valid = 1; b_addr = 9; b_data = 64'h99;
        step();
        b_valid = 0; issue_valid = 0;
`ifdef REG_WB_SCOREBOARD_EN
        chk("r037_busy9_set", busy[9], 1);
`else
        chk("r037_busy9_off", busy[9], 0);
`endif
        a_valid = 1; a_addr = 9; a_data = 64'h9A;
        step();
        a_valid = 0;
        chk("r037_busy9_clr", busy[9], 0);
        issue_valid = 1; issue_rd = 3;
        step();
        issue_valid = 0;
`ifdef REG_WB_SCOREBOARD_EN
        chk("r038_busy", busy, 32'h8);
`else
        chk("r038_busy", busy, 32'h0);
`endif

        // Transfer just before reset must not survive the reset edge.
        a_valid = 1; a_addr = 6; a_data = 64'h66;
        step();
        rst = 1; a_addr = 7; a_data = 64'h77;
        step();
        chk("r036_a_ready", obs_a, 0);
        chk("r036_we", we, 0);
        chk("r036_busy", busy, 0);
        rst = 0;
        step();
        chk("r036_represent_we", we, 1);
        chk("r036_represent_waddr", waddr, 7);
        a_valid = 0;

        // Randomized traffic obeying the hold-until-accepted protocol.
        for (int n = 0; n < 600; n++) begin
            issue_valid = $urandom_range(0, 1);
            issue_rd    = 5'($urandom_range(0, 31));
            step();
            if (!a_valid || ga) begin
                a_valid = ($urandom_range(0, 3) != 0);
                a_addr  = 5'($urandom_range(0, 31));
                a_data  = {$urandom, $urandom};
            end
            if (!b_valid || gb) begin
                b_valid = ($urandom_range(0, 2) != 0);
                b_addr  = 5'($urandom_range(0, 31));
                b_data  = {$urandom, $urandom};
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 Parameter XLEN, default 64, data width of the register-file write port.
REQ-002 Parameter STARVE_LIMIT, default 3, consecutive denied cycles of source B before B is forced through.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 a_valid  input  1  source A (ALU writeback) request.
REQ-006 a_addr  input  5  source A destination register.
REQ-007 a_data  input  XLEN  source A write data.
REQ-008 a_ready  output  1  source A accepted this cycle (combinational).
REQ-009 b_valid / b_addr / b_data  input  1 / 5 / XLEN  source B (load/mul-div writeback) request, address, data.
REQ-010 b_ready  output  1  source B accepted this cycle (combinational).
REQ-011 we / waddr / wdata  output  1 / 5 / XLEN  registered write port to the register file.
REQ-012 issue_valid / issue_rd  input  1 / 5  decode issued an instruction writing issue_rd.
REQ-013 busy  output  32  per-register pending-write mask.

Function
REQ-014 At most one of a_ready, b_ready SHALL be 1 in any cycle; a transfer occurs when valid and ready are both 1.
REQ-015 Requesters SHALL hold valid, addr, data stable until accepted; arbiter SHALL NOT depend on retraction.
REQ-016 State machine, two states: PRIO_A (A wins when both valid) and FORCE_B (B wins when b_valid, else A).
REQ-017 starve_cnt SHALL increment each cycle b_valid=1 and b_ready=0, clear on B transfer or b_valid=0, saturate at STARVE_LIMIT.
REQ-018 PRIO_A -> FORCE_B when starve_cnt reaches STARVE_LIMIT; FORCE_B -> PRIO_A on the cycle after a B transfer.
REQ-019 Single valid source SHALL be granted the same cycle regardless of state.
REQ-020 Accepted transfer SHALL appear on we/waddr/wdata exactly one cycle later; we=0 in cycles after no transfer.
REQ-021 Transfer with addr=0 SHALL be accepted (ready=1) but SHALL produce we=0 next cycle.
REQ-022 waddr/wdata SHALL hold last value when we=0.
REQ-023 Same address on A and B simultaneously: only the granted source transfers; the other waits, no merge.
REQ-024 Sustained throughput SHALL be one write per cycle with no bubbles while any valid is asserted.

Reset
REQ-025 While rst=1: a_ready=0, b_ready=0; next edge sets we=0, waddr=0, wdata=0, busy=0, state=PRIO_A, starve_cnt=0.
REQ-026 Request pending when rst asserts SHALL be dropped; requester re-presents after reset.
REQ-027 Transfer accepted the cycle before rst SHALL NOT produce we=1 after the reset edge.

Configuration
REQ-028 Macro REG_WB_SCOREBOARD_EN compiles in the busy scoreboard.
REQ-029 With macro: issue_valid with issue_rd!=0 sets busy[issue_rd] at next edge; accepted transfer with addr!=0 clears busy[addr] at next edge.
REQ-030 With macro: set and clear of the same register in one cycle -> set wins (busy=1).
REQ-031 With macro: busy[0] SHALL be constant 0.
REQ-032 Without macro: busy SHALL be constant 32'h0, issue_valid/issue_rd ignored, no scoreboard flops.

Verification
REQ-033 a_valid=1 a_addr=5 a_data=0x11 alone -> a_ready=1 same cycle; next cycle we=1 waddr=5 wdata=0x11.
REQ-034 a_valid and b_valid held continuously, STARVE_LIMIT=3 -> A granted 3 cycles, B granted 4th cycle, A again 5th.
REQ-035 b_valid=1 b_addr=0 b_data=0xFF -> b_ready=1, next cycle we=0.
REQ-036 rst asserted on cycle A transfers addr=7 -> we=0 after reset edge, busy=0, a_ready=0 during rst.
REQ-037 Macro on: issue_rd=9, then B writes addr=9 while issue_rd=9 reissued same cycle -> busy[9] stays 1; later A writes 9 alone -> busy[9]=0.
REQ-038 Macro off: issue_valid=1 issue_rd=3 -> busy remains 32'h0.
